fp_adder_arbiter: RTL and testbench
===================================

Name: fp_adder_arbiter

Overview:
Shares one pipelined IEEE-754 single-precision adder between NUM_REQ requesters using round-robin arbitration. It accepts operand pairs over valid/ready handshakes and drives the adder's add_sub_bit/inputA/inputB from registers. A tag pipeline matched to adder latency routes each outputC back to its requester as a one-cycle result pulse. The block sits between client blocks (accumulators, sequencers) and the adder instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, requester id width, must equal clog2(NUM_REQ)
ADDER_LATENCY, 3, clocks from adder input register to valid outputC (>=1)

Ports:
clock_in  in  1  clock, all logic on rising edge
reset_in  in  1  synchronous, active-high reset
hold_in  in  1  when 1, no new grants; in-flight operations still complete
req_valid  in  NUM_REQ  per-requester operation valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_op  in  NUM_REQ  per-requester add_sub_bit (0 = add, 1 = subtract)
req_a  in  NUM_REQ*32  operand A, requester i at [32i+31:32i]
req_b  in  NUM_REQ*32  operand B, same packing
add_sub_bit  out  1  to adder, registered
inputA  out  32  to adder, registered
inputB  out  32  to adder, registered
outputC  in  32  from adder
res_valid  out  1  one-cycle pulse: result available
res_id  out  ID_W  requester owning the result
res_data  out  32  result (outputC passed through)
busy  out  1  1 while any operation is in flight

Behaviour:
- Reset: add_sub_bit=0, inputA=0, inputB=0, res_valid=0, res_id=0, busy=0. RR pointer=0. Tag pipeline cleared.
- Grant: combinational. If hold_in=0 and any req_valid, req_ready[g]=1 for the first valid index at or after the pointer, wrapping. Transfer occurs on req_valid&req_ready.
- On transfer: register req_op/req_a/req_b of g into the adder inputs. Push {valid=1, id=g} into tag stage 0. Pointer <= (g+1) mod NUM_REQ.
- No transfer: adder inputs hold their last value; tag stage 0 gets valid=0; pointer unchanged.
- Tag pipeline: ADDER_LATENCY stages. res_valid/res_id = last stage, combinational. res_data=outputC.
- Total latency: handshake edge to res_valid is ADDER_LATENCY+1 cycles.
- Throughput: one op per cycle; back-to-back grants to the same requester are allowed when it is the only one valid.
- No result back-pressure: a requester must consume res_* in the pulse cycle.
- busy = OR of all tag-stage valid bits.
- hold_in=1: req_ready=0 and the pointer is frozen. Results keep draining.
- Reset mid-operation: all tags are cleared. No res_valid is issued for pre-reset operations even if the adder still emits data.
- req_valid deasserted before grant: no transfer and no state change. Requests may be withdrawn freely.
- NUM_REQ not a power of two: pointer wrap uses an explicit compare, never bit truncation.

Optional Feature:
FP_ARB_STATS_EN
- Defined: adds ports stat_sel (in, ID_W) and stat_count (out, 16). One 16-bit saturating grant counter per requester, incremented on each transfer and cleared on reset. stat_count = counter[stat_sel], combinational. Saturates at 16'hFFFF.
- Undefined: no counters and no stat ports. Core behaviour is identical.

Decomposition:
- Include file fp_arb_defs.vh holds: op encodings (FP_OP_ADD=0, FP_OP_SUB=1), operand width 32, and the stat counter width.
- One sub-module, rr_arbiter. Inputs: req vector, pointer, enable. Output: one-hot grant plus encoded index.
- Pointer update, operand registers and tag pipeline live in the top module.

Test Plan:
- Single request: req 0, A=0x3FC00000 (1.5), B=0x3F000000 (0.5), op=0 -> res_valid after ADDER_LATENCY+1 cycles, res_id=0, res_data=0x40000000. busy high only in between.
- All four requesters valid continuously, each with distinct operands -> grants in order 0,1,2,3,0,... one per cycle. Results return in the same order with matching ids and correct sums (e.g. 2.0+1.0=0x40400000).
- Requesters 1 and 3 only -> grants alternate 1,3,1,3. Requesters 0 and 2 never see req_ready.
- hold_in=1 for 5 cycles mid-stream -> no req_ready during hold; in-flight results still emerge; arbitration resumes from the frozen pointer.
- reset_in pulsed one cycle after a grant -> no res_valid for that operation. Outputs at reset values next cycle; pointer=0.
- FP_ARB_STATS_EN defined, 10 grants to requester 2 -> stat_sel=2 reads stat_count=10; other counters unaffected.

Source files
------------

// File: rtl/fp_adder_arbiter_pkg.sv
// Shared types and widths for the round-robin front end of the single-precision adder.
package fp_adder_arbiter_pkg;

  localparam int FP_W   = 32;
  localparam int STAT_W = 16;

  typedef enum logic {
    FP_OP_ADD = 1'b0,
    FP_OP_SUB = 1'b1
  } fp_op_e;

endpackage

// File: rtl/fp_adder_arbiter_if.sv
// Requester-side bundle: per-requester operand handshakes plus the shared result pulse.
interface fp_adder_arbiter_if
  import fp_adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) ();

  logic [NUM_REQ-1:0]      req_valid;
  logic [NUM_REQ-1:0]      req_ready;
  logic [NUM_REQ-1:0]      req_op;
  logic [NUM_REQ*FP_W-1:0] req_a;
  logic [NUM_REQ*FP_W-1:0] req_b;
  logic                    res_valid;
  logic [ID_W-1:0]         res_id;
  logic [FP_W-1:0]         res_data;

  modport master (
    output req_valid, req_op, req_a, req_b,
    input  req_ready, res_valid, res_id, res_data
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b,
    output req_ready, res_valid, res_id, res_data
  );

endinterface

// File: rtl/fp_adder_arbiter_rr.sv
// Combinational round-robin pick: first requester at or after the pointer, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx
);

  logic [ID_W:0] w_cand;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // explicit wrap keeps non-power-of-two requester counts correct
      w_cand = {1'b0, i_ptr} + (ID_W+1)'(i);
      if (w_cand >= (ID_W+1)'(NUM_REQ)) begin
        w_cand = w_cand - (ID_W+1)'(NUM_REQ);
      end
      if (i_en && !w_found && i_req[w_cand[ID_W-1:0]]) begin
        o_grant[w_cand[ID_W-1:0]] = 1'b1;
        o_idx                     = w_cand[ID_W-1:0];
        w_found                   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fp_adder_arbiter.sv
// Shares one pipelined FP32 adder among NUM_REQ requesters; results are routed back by tag.
// Optional per-requester grant counters are built when FP_ARB_STATS_EN is defined.
module fp_adder_arbiter
  import fp_adder_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = 4,
  parameter int ID_W          = 2,
  parameter int ADDER_LATENCY = 3
) (
  input  logic               clock_in,
  input  logic               reset_in,
  input  logic               hold_in,
  fp_adder_arbiter_if.slave  bus,
  output logic               add_sub_bit,
  output logic [FP_W-1:0]    inputA,
  output logic [FP_W-1:0]    inputB,
  input  logic [FP_W-1:0]    outputC,
  output logic               busy
`ifdef FP_ARB_STATS_EN
  ,
  input  logic [ID_W-1:0]    stat_sel,
  output logic [STAT_W-1:0]  stat_count
`endif
);

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_gnt_idx;
  logic               w_arb_en;
  logic               w_fire;

  logic [ID_W-1:0]    r_ptr;
  logic               r_op_p0;
  logic [FP_W-1:0]    r_a_p0;
  logic [FP_W-1:0]    r_b_p0;

  // Stage 0 travels with the operand registers; stages 1..ADDER_LATENCY track the adder.
  logic [ADDER_LATENCY:0] r_tag_vld;
  logic [ID_W-1:0]        r_tag_id [0:ADDER_LATENCY];

  assign w_arb_en = !hold_in;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_gnt_idx)
  );

  assign bus.req_ready = w_grant;
  assign w_fire        = |(bus.req_valid & w_grant);

  // Issue stage: capture the granted operands and advance the pointer.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_ptr   <= '0;
      r_op_p0 <= FP_OP_ADD;
      r_a_p0  <= '0;
      r_b_p0  <= '0;
    end else if (w_fire) begin
      r_ptr   <= (w_gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
      r_op_p0 <= bus.req_op[w_gnt_idx];
      r_a_p0  <= bus.req_a[{w_gnt_idx, 5'd0} +: FP_W];
      r_b_p0  <= bus.req_b[{w_gnt_idx, 5'd0} +: FP_W];
    end
  end

  assign add_sub_bit = r_op_p0;
  assign inputA      = r_a_p0;
  assign inputB      = r_b_p0;

  // Tag stages: valid/id shadow the operation through the adder.
  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      r_tag_vld <= '0;
      for (int k = 0; k <= ADDER_LATENCY; k++) begin
        r_tag_id[k] <= '0;
      end
    end else begin
      r_tag_vld   <= {r_tag_vld[ADDER_LATENCY-1:0], w_fire};
      r_tag_id[0] <= w_gnt_idx;
      for (int k = 1; k <= ADDER_LATENCY; k++) begin
        r_tag_id[k] <= r_tag_id[k-1];
      end
    end
  end

  assign bus.res_valid = r_tag_vld[ADDER_LATENCY];
  assign bus.res_id    = r_tag_id[ADDER_LATENCY];
  assign bus.res_data  = outputC;
  assign busy          = |r_tag_vld;

`ifdef FP_ARB_STATS_EN
  logic [STAT_W-1:0] r_stat_cnt [NUM_REQ];

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        r_stat_cnt[k] <= '0;
      end
    end else if (w_fire) begin
      r_stat_cnt[w_gnt_idx] <= sat_inc(r_stat_cnt[w_gnt_idx]);
    end
  end

  assign stat_count = (32'(stat_sel) < NUM_REQ) ? r_stat_cnt[stat_sel] : '0;
`endif

endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter with a behavioural pipelined FP32 adder attached.
module tb_fp_adder_arbiter;

  localparam int L = 3;

  logic        clk = 1'b0;
  logic        reset_in;
  logic        hold_in;
  logic        add_sub_bit;
  logic [31:0] inputA;
  logic [31:0] inputB;
  logic [31:0] outputC;
  logic        busy;
`ifdef FP_ARB_STATS_EN
  logic [1:0]  stat_sel;
  logic [15:0] stat_count;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  fp_adder_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();

  fp_adder_arbiter #(
    .NUM_REQ       (4),
    .ID_W          (2),
    .ADDER_LATENCY (L)
  ) dut (
    .clock_in    (clk),
    .reset_in    (reset_in),
    .hold_in     (hold_in),
    .bus         (bus),
    .add_sub_bit (add_sub_bit),
    .inputA      (inputA),
    .inputB      (inputB),
    .outputC     (outputC),
    .busy        (busy)
`ifdef FP_ARB_STATS_EN
    ,
    .stat_sel    (stat_sel),
    .stat_count  (stat_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural adder: normal numbers and zero only, exact for the vectors used here.
  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == 31'd0) d = {s[31], 63'd0};
    else d = {s[31], {3'b000, s[30:23]} + 11'd896, s[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2s(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpadd(input logic sub, input logic [31:0] a, input logic [31:0] b);
    real ra;
    real rb;
    ra = s2r(a);
    rb = s2r(b);
    return r2s(sub ? ra - rb : ra + rb);
  endfunction

  logic [31:0] apipe [1:L];
  always @(posedge clk) begin
    apipe[1] <= fpadd(add_sub_bit, inputA, inputB);
    for (int k = 2; k <= L; k++) apipe[k] <= apipe[k-1];
  end
  assign outputC = apipe[L];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int          id;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } sb_t;

  vec_t tab [0:22];
  sb_t  sb [$];
  sb_t  mon_e;

  always @(negedge clk) begin
    if (bus.res_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_result: got id %0d data %h, expected no result (cycle %0d)",
                 bus.res_id, bus.res_data, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("res_id", 32'(bus.res_id), 32'(mon_e.id));
        chk("res_data", bus.res_data, mon_e.data);
        chk("res_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end else if (sb.size() > 0 && cyc > sb[0].due) begin
      n_checks++;
      n_errors++;
      $display("FAIL missing_result: got nothing by cycle %0d, expected id %0d data %h",
               cyc, sb[0].id, sb[0].data);
      void'(sb.pop_front());
    end
  end

  task automatic run_table(input int first, input int count, input int hold_after, input int hold_len);
    int q [4][$];
    int expk;
    int grants;
    int hold_cnt;
    int budget;
    int g;
    logic hold;
    logic [3:0]   v;
    logic [3:0]   op;
    logic [127:0] va;
    logic [127:0] vb;
    for (int k = first; k < first + count; k++) q[tab[k].id].push_back(k);
    expk = first; grants = 0; hold_cnt = 0; budget = 0;
    while (expk < first + count && budget < 100) begin
      hold = (grants == hold_after) && (hold_cnt < hold_len);
      v = '0; op = '0; va = '0; vb = '0;
      for (int i = 0; i < 4; i++) begin
        if (q[i].size() > 0) begin
          v[i]          = 1'b1;
          op[i]         = tab[q[i][0]].op;
          va[32*i +: 32] = tab[q[i][0]].a;
          vb[32*i +: 32] = tab[q[i][0]].b;
        end
      end
      bus.req_valid = v;
      bus.req_op    = op;
      bus.req_a     = va;
      bus.req_b     = vb;
      hold_in       = hold;
      @(negedge clk);
      chk("ready_onehot", 32'($onehot0(bus.req_ready)), 32'd1);
      if (hold) begin
        chk("ready_in_hold", 32'(bus.req_ready), 32'd0);
        hold_cnt++;
      end else if ((bus.req_valid & bus.req_ready) != 4'd0) begin
        g = 0;
        for (int i = 3; i >= 0; i--) if (bus.req_ready[i]) g = i;
        chk("grant_id", 32'(g), 32'(tab[expk].id));
        sb.push_back('{tab[expk].id, tab[expk].exp, cyc + L + 1});
        if (q[g].size() > 0) void'(q[g].pop_front());
        expk++;
        grants++;
      end
      @(posedge clk); #1;
      budget++;
    end
    if (expk < first + count) begin
      n_checks++;
      n_errors++;
      $display("FAIL grant_timeout: got %0d grants, expected %0d", expk - first, count);
    end
    bus.req_valid = '0;
    hold_in       = 1'b0;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while (sb.size() > 0 && b < 30) begin
      @(posedge clk); #1;
      b++;
    end
    if (sb.size() > 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL drain: got %0d results outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  int c;

  initial begin
    // all four requesters, grants 0,1,2,3,0,1,2,3
    tab[0]  = '{0, 1'b0, 32'h40000000, 32'h3F800000, 32'h40400000};
    tab[1]  = '{1, 1'b0, 32'h3FC00000, 32'h3F000000, 32'h40000000};
    tab[2]  = '{2, 1'b1, 32'h40400000, 32'h3F800000, 32'h40000000};
    tab[3]  = '{3, 1'b0, 32'h40800000, 32'h40000000, 32'h40C00000};
    tab[4]  = '{0, 1'b1, 32'h3F800000, 32'h3F000000, 32'h3F000000};
    tab[5]  = '{1, 1'b0, 32'h3E800000, 32'h3E800000, 32'h3F000000};
    tab[6]  = '{2, 1'b0, 32'h41200000, 32'h40C00000, 32'h41800000};
    tab[7]  = '{3, 1'b1, 32'h40000000, 32'h41000000, 32'hC0C00000};
    // requesters 1 and 3 only
    tab[8]  = '{1, 1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000};
    tab[9]  = '{3, 1'b0, 32'h40000000, 32'h40000000, 32'h40800000};
    tab[10] = '{1, 1'b1, 32'h40A00000, 32'h3F800000, 32'h40800000};
    tab[11] = '{3, 1'b0, 32'h3F000000, 32'h3F000000, 32'h3F800000};
    tab[12] = '{0, 1'b0, 32'h3FC00000, 32'h3F000000, 32'h40000000};
    // hold stream, pointer starts at 1
    tab[13] = '{1, 1'b0, 32'h3F800000, 32'h40000000, 32'h40400000};
    tab[14] = '{2, 1'b0, 32'h3F000000, 32'h3E800000, 32'h3F400000};
    tab[15] = '{3, 1'b1, 32'h3F800000, 32'h3E800000, 32'h3F400000};
    tab[16] = '{0, 1'b0, 32'h40400000, 32'h40400000, 32'h40C00000};
    tab[17] = '{1, 1'b1, 32'h41000000, 32'h40000000, 32'h40C00000};
    tab[18] = '{2, 1'b0, 32'h3FC00000, 32'h3FC00000, 32'h40400000};
    tab[19] = '{3, 1'b0, 32'h41800000, 32'h41800000, 32'h42000000};
    tab[20] = '{0, 1'b1, 32'h3F000000, 32'h40000000, 32'hBFC00000};
    // after mid-operation reset, pointer back at 0
    tab[21] = '{1, 1'b0, 32'h3F800000, 32'h3F000000, 32'h3FC00000};
    tab[22] = '{3, 1'b1, 32'h40000000, 32'h3F000000, 32'h3FC00000};

    reset_in      = 1'b1;
    hold_in       = 1'b0;
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
`ifdef FP_ARB_STATS_EN
    stat_sel = 2'd0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_add_sub_bit", 32'(add_sub_bit), 32'd0);
    chk("rst_inputA", inputA, 32'd0);
    chk("rst_inputB", inputB, 32'd0);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_id", 32'(bus.res_id), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    reset_in = 1'b0;

    run_table(0, 8, -1, 0);
    drain();
    run_table(8, 4, -1, 0);
    drain();

    // single request with busy window and registered operands
    bus.req_valid = 4'b0001;
    bus.req_op    = 4'b0000;
    bus.req_a     = {96'd0, 32'h3FC00000};
    bus.req_b     = {96'd0, 32'h3F000000};
    @(negedge clk);
    chk("single_ready", 32'(bus.req_ready), 32'd1);
    chk("single_busy_before", 32'(busy), 32'd0);
    c = cyc;
    sb.push_back('{0, 32'h40000000, c + L + 1});
    @(posedge clk); #1;
    bus.req_valid = '0;
    for (int k = 1; k <= L + 2; k++) begin
      @(negedge clk);
      chk("single_busy", 32'(busy), (k <= L + 1) ? 32'd1 : 32'd0);
      if (k == 1) begin
        chk("single_inputA", inputA, 32'h3FC00000);
        chk("single_inputB", inputB, 32'h3F000000);
        chk("single_op", 32'(add_sub_bit), 32'd0);
      end
    end
    @(posedge clk); #1;
    drain();

    run_table(13, 8, 2, 5);
    drain();

    // reset one cycle after a grant: that operation must never report
    bus.req_valid = 4'b0100;
    bus.req_op    = 4'b0100;
    bus.req_a     = {32'd0, 32'h3F800000, 64'd0};
    bus.req_b     = {32'd0, 32'h3F800000, 64'd0};
    @(negedge clk);
    chk("rstmid_ready", 32'(bus.req_ready), 32'd4);
    @(posedge clk); #1;
    bus.req_valid = '0;
    reset_in      = 1'b1;
    @(posedge clk); #1;
    reset_in = 1'b0;
    @(negedge clk);
    chk("rstmid_add_sub_bit", 32'(add_sub_bit), 32'd0);
    chk("rstmid_inputA", inputA, 32'd0);
    chk("rstmid_inputB", inputB, 32'd0);
    chk("rstmid_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rstmid_busy", 32'(busy), 32'd0);
    repeat (L + 3) @(negedge clk);
    chk("rstmid_busy_later", 32'(busy), 32'd0);
    @(posedge clk); #1;
    run_table(21, 2, -1, 0);
    drain();

`ifdef FP_ARB_STATS_EN
    bus.req_valid = 4'b0100;
    bus.req_op    = 4'b0000;
    bus.req_a     = '0;
    bus.req_b     = '0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("stat_ready", 32'(bus.req_ready), 32'd4);
      sb.push_back('{2, 32'h00000000, cyc + L + 1});
      @(posedge clk); #1;
    end
    bus.req_valid = '0;
    drain();
    stat_sel = 2'd2;
    @(negedge clk);
    chk("stat_count_2", 32'(stat_count), 32'd10);
    @(posedge clk); #1;
    stat_sel = 2'd1;
    @(negedge clk);
    chk("stat_count_1", 32'(stat_count), 32'd1);
    @(posedge clk); #1;
    stat_sel = 2'd0;
    @(negedge clk);
    chk("stat_count_0", 32'(stat_count), 32'd0);
    @(posedge clk); #1;
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
